// File: rtl/elixirchip_es1_spu_pkg.sv
// elixirchip_es1_spu_pkg: shared types and constants for the SPU accumulator drain path.
package elixirchip_es1_spu_pkg;
    localparam int DROP_CNT_BITS = 8;
    localparam int DRAIN_DATA_BITS = 16;
    typedef struct packed {
        logic                       ovf;
        logic [DRAIN_DATA_BITS-1:0] data;
    } drain_entry_t;
endpackage

// File: rtl/elixirchip_es1_spu_fifo_sync.sv
// elixirchip_es1_spu_fifo_sync: show-ahead synchronous FIFO with pointer/count tracking.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module elixirchip_es1_spu_fifo_sync #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 cke,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic [DATA_BITS-1:0] m_data,
    input  logic                 m_ready,
    output logic                 full,
    output logic                 empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic push, pop;
    assign empty = count == '0;
    assign full = count == (AW+1)'(DEPTH);
    assign pop = cke & ~empty & m_ready;
    assign push = cke & s_valid & (~full | pop);
    assign m_data = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end
endmodule

// File: rtl/elixirchip_es1_spu_op_acc_drain.sv
// elixirchip_es1_spu_op_acc_drain: captures accumulator results, shifts/saturates them and queues them on a stream.
// ELIXIRCHIP_ES1_SPU_OP_ACC_DRAIN_ROUND_EN selects round-half-up before the shift instead of truncation.
module elixirchip_es1_spu_op_acc_drain
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int M_DATA_BITS = 32,
    parameter int O_DATA_BITS = 16,
    parameter int SHIFT       = 0,
    parameter int SIGNED      = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     cke,
    input  logic                     s_carry,
    input  logic [M_DATA_BITS-1:0]   s_data,
    input  logic                     s_last,
    input  logic                     s_valid,
    input  logic                     s_clear_status,
    output logic [O_DATA_BITS-1:0]   m_data,
    output logic                     m_ovf,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_drop,
    output logic [DROP_CNT_BITS-1:0] m_drop_count
);
    // carry/sign bit plus one guard bit so rounding never wraps
    localparam int E = M_DATA_BITS + 2;
    localparam logic signed [E-1:0] ONE = 1;
    localparam logic signed [E-1:0] HI = SIGNED != 0 ? (ONE <<< (O_DATA_BITS-1)) - ONE : (ONE <<< O_DATA_BITS) - ONE;
    localparam logic signed [E-1:0] LO = SIGNED != 0 ? ~HI : '0;
`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_DRAIN_ROUND_EN
    localparam logic signed [E-1:0] RND = (ONE <<< SHIFT) >>> 1;
`endif
    logic signed [E-1:0] v, r, sh;
    logic sat_hi, sat_lo;
    logic [O_DATA_BITS-1:0] q;
    logic s1_valid;
    logic [O_DATA_BITS:0] s1_entry, head;
    logic full, empty, pop, drop;
    always_comb begin
        v = SIGNED != 0 ? E'($signed(s_data)) : E'({s_carry, s_data});
`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_DRAIN_ROUND_EN
        r = v + RND;
`else
        r = v;
`endif
        sh = r >>> SHIFT;
        sat_hi = sh > HI;
        sat_lo = sh < LO;
        q = sat_hi ? HI[O_DATA_BITS-1:0] : sat_lo ? LO[O_DATA_BITS-1:0] : sh[O_DATA_BITS-1:0];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_entry <= '0;
        end else if (cke) begin
            s1_valid <= s_valid & s_last;
            if (s_valid & s_last) s1_entry <= {sat_hi | sat_lo, q};
        end
    end
    elixirchip_es1_spu_fifo_sync #(
        .DATA_BITS(O_DATA_BITS + 1),
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .reset  (reset),
        .clk    (clk),
        .cke    (cke),
        .s_data (s1_entry),
        .s_valid(s1_valid),
        .m_data (head),
        .m_ready(m_ready),
        .full   (full),
        .empty  (empty)
    );
    assign m_valid = ~empty;
    assign {m_ovf, m_data} = head;
    assign pop = cke & m_valid & m_ready;
    assign drop = cke & s1_valid & full & ~pop;
    // a clear wins over a drop in the same cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_drop <= 1'b0;
            m_drop_count <= '0;
        end else if (cke) begin
            if (s_clear_status) begin
                m_drop <= 1'b0;
                m_drop_count <= '0;
            end else if (drop) begin
                m_drop <= 1'b1;
                if (m_drop_count != '1) m_drop_count <= m_drop_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_elixirchip_es1_spu_op_acc_drain.sv
// tb_elixirchip_es1_spu_op_acc_drain: self-checking bench for the drain stage (M=16, O=8, SHIFT=4, depth 4).
// Honours ELIXIRCHIP_ES1_SPU_OP_ACC_DRAIN_ROUND_EN when it is defined for the build.
module tb_elixirchip_es1_spu_op_acc_drain;
    localparam int D = 4;
`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_DRAIN_ROUND_EN
    localparam logic [7:0] R12 = 8'h13;
`else
    localparam logic [7:0] R12 = 8'h12;
`endif
    logic clk = 0, reset = 1, cke = 1, s_carry = 0, s_last = 0, s_valid = 0, s_clear_status = 0, m_ready = 0;
    logic [15:0] s_data = 0;
    logic [7:0] m_data, u_m_data, m_drop_count, u_m_drop_count;
    logic m_ovf, m_valid, m_drop, u_m_ovf, u_m_valid, u_m_drop;
    int errors = 0, checks = 0;

    typedef struct { logic [8:0] s; logic [8:0] u; } exp_t;
    typedef struct { logic c; logic [15:0] d; logic [8:0] s; logic [8:0] u; } vec_t;
    exp_t q[$];
    exp_t s1e;
    bit s1v, mdrop;
    int mcnt;
    vec_t tbl[12];

    always #5 clk = ~clk;

    elixirchip_es1_spu_op_acc_drain #(.M_DATA_BITS(16), .O_DATA_BITS(8), .SHIFT(4), .SIGNED(1), .FIFO_DEPTH(D)) dut (
        .reset(reset), .clk(clk), .cke(cke), .s_carry(s_carry), .s_data(s_data), .s_last(s_last),
        .s_valid(s_valid), .s_clear_status(s_clear_status), .m_data(m_data), .m_ovf(m_ovf),
        .m_valid(m_valid), .m_ready(m_ready), .m_drop(m_drop), .m_drop_count(m_drop_count));

    elixirchip_es1_spu_op_acc_drain #(.M_DATA_BITS(16), .O_DATA_BITS(8), .SHIFT(4), .SIGNED(0), .FIFO_DEPTH(D)) dut_u (
        .reset(reset), .clk(clk), .cke(cke), .s_carry(s_carry), .s_data(s_data), .s_last(s_last),
        .s_valid(s_valid), .s_clear_status(s_clear_status), .m_data(u_m_data), .m_ovf(u_m_ovf),
        .m_valid(u_m_valid), .m_ready(m_ready), .m_drop(u_m_drop), .m_drop_count(u_m_drop_count));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {ovf, data}: widen, optionally round, floor-divide by 16, clamp to the output range
    function automatic logic [8:0] ref_val(input bit sgn, input bit c, input logic [15:0] d);
        longint v, qv, lo, hi;
        v = sgn ? longint'($signed(d)) : (longint'(c) << 16) + longint'(d);
`ifdef ELIXIRCHIP_ES1_SPU_OP_ACC_DRAIN_ROUND_EN
        v = v + 8;
`endif
        qv = v >>> 4;
        lo = sgn ? -128 : 0;
        hi = sgn ? 127 : 255;
        if (qv > hi) return {1'b1, hi[7:0]};
        if (qv < lo) return {1'b1, lo[7:0]};
        return {1'b0, qv[7:0]};
    endfunction

    task automatic model_reset();
        q.delete();
        s1v = 0;
        mdrop = 0;
        mcnt = 0;
    endtask

    task automatic compare_all();
        chk("valid", m_valid, q.size() != 0);
        chk("u_valid", u_m_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("head", {m_ovf, m_data}, q[0].s);
            chk("u_head", {u_m_ovf, u_m_data}, q[0].u);
        end
        chk("drop", m_drop, mdrop);
        chk("drop_count", m_drop_count, mcnt);
        chk("u_drop", u_m_drop, mdrop);
        chk("u_drop_count", u_m_drop_count, mcnt);
    endtask

    // advance the reference by one clock using the inputs currently driven, then compare
    task automatic step();
        bit pop, full, drop;
        if (cke) begin
            pop = q.size() != 0 && m_ready;
            full = q.size() == D;
            drop = 0;
            if (pop) void'(q.pop_front());
            if (s1v) begin
                if (!full || pop) q.push_back(s1e);
                else drop = 1;
            end
            if (s_clear_status) begin
                mdrop = 0;
                mcnt = 0;
            end else if (drop) begin
                mdrop = 1;
                if (mcnt < 255) mcnt++;
            end
            s1v = s_valid && s_last;
            if (s1v) s1e = '{ref_val(1, s_carry, s_data), ref_val(0, s_carry, s_data)};
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic cap(input logic [15:0] d);
        s_valid = 1;
        s_last = 1;
        s_carry = 0;
        s_data = d;
        step();
        s_valid = 0;
        s_last = 0;
    endtask

    task automatic drain_clear();
        s_valid = 0;
        m_ready = 1;
        for (int i = 0; i < 8; i++) step();
        s_clear_status = 1;
        step();
        s_clear_status = 0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 16'h0128, {1'b0, R12}, {1'b0, R12}};
        tbl[1]  = '{1'b0, 16'h7FFF, 9'h17F, 9'h1FF};
        tbl[2]  = '{1'b0, 16'h8000, 9'h180, 9'h1FF};
        tbl[3]  = '{1'b1, 16'h0000, 9'h000, 9'h1FF};
        tbl[4]  = '{1'b0, 16'h00A0, 9'h00A, 9'h00A};
        tbl[5]  = '{1'b0, 16'hFFF0, 9'h0FF, 9'h1FF};
        tbl[6]  = '{1'b0, 16'h07F0, 9'h07F, 9'h07F};
        tbl[7]  = '{1'b0, 16'h0800, 9'h17F, 9'h080};
        tbl[8]  = '{1'b0, 16'hF800, 9'h080, 9'h1FF};
        tbl[9]  = '{1'b0, 16'hF7F0, 9'h180, 9'h1FF};
        tbl[10] = '{1'b0, 16'h0FF0, 9'h17F, 9'h0FF};
        tbl[11] = '{1'b0, 16'h1000, 9'h17F, 9'h1FF};

        #1 reset = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_ovf", m_ovf, 0);
        chk("rst_drop", m_drop, 0);
        chk("rst_drop_count", m_drop_count, 0);
        reset = 1;

        // table: one capture each, two-edge latency, then popped
        m_ready = 1;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1;
            s_last = 1;
            s_carry = tbl[i].c;
            s_data = tbl[i].d;
            step();
            s_valid = 0;
            s_last = 0;
            chk("lat_n1_valid", m_valid, 0);
            step();
            chk("lat_n2_valid", m_valid, 1);
            chk($sformatf("tbl%0d_s", i), {m_ovf, m_data}, tbl[i].s);
            chk($sformatf("tbl%0d_u", i), {u_m_ovf, u_m_data}, tbl[i].u);
            step();
        end

        // s_valid without s_last must not capture
        s_valid = 1;
        s_last = 0;
        s_data = 16'h0100;
        step();
        s_valid = 0;
        step();
        chk("no_last_valid", m_valid, 0);

        // overflow with backpressure: 6 captures into depth 4
        drain_clear();
        m_ready = 0;
        for (int k = 1; k <= 6; k++) cap(16'(k << 4));
        chk("ovf_drop", m_drop, 1);
        chk("ovf_drop_count", m_drop_count, 1);
        m_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_drain", m_data, k);
            step();
        end
        s_clear_status = 1;
        step();
        s_clear_status = 0;
        chk("clear_drop_count", m_drop_count, 0);
        chk("clear_drop", m_drop, 0);

        // full FIFO with concurrent pop every cycle
        drain_clear();
        m_ready = 0;
        for (int k = 1; k <= 5; k++) cap(16'(k << 4));
        m_ready = 1;
        for (int j = 0; j < 10; j++) begin
            chk("full_order", m_data, j + 1);
            cap(16'((j + 6) << 4));
        end
        chk("full_no_drop", m_drop_count, 0);

        // cke low holds everything
        drain_clear();
        cap(16'h0050);
        step();
        cke = 0;
        for (int i = 0; i < 3; i++) step();
        chk("cke_hold_valid", m_valid, 1);
        chk("cke_hold_data", m_data, 8'h05);
        cke = 1;
        step();

        // reset with three entries queued
        drain_clear();
        m_ready = 0;
        for (int k = 1; k <= 3; k++) cap(16'(k << 4));
        step();
        chk("pre_rst_valid", m_valid, 1);
        #1 reset = 0;
        #1;
        chk("async_rst_valid", m_valid, 0);
        chk("async_rst_u_valid", u_m_valid, 0);
        model_reset();
        @(posedge clk);
        #1 reset = 1;
        m_ready = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_valid", m_valid, 0);
        end

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            cke = $urandom_range(0, 9) != 0;
            s_valid = $urandom_range(0, 3) != 0;
            s_last = $urandom_range(0, 3) != 0;
            s_carry = 1'($urandom);
            s_data = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 4095));
            m_ready = (i % 300 < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            s_clear_status = $urandom_range(0, 60) == 0;
            step();
        end
        cke = 1;
        s_valid = 0;
        s_clear_status = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/elixirchip_es1_spu_op_acc_drain.md
# elixirchip_es1_spu_op_acc_drain

Downstream stage of the SPU accumulator. It samples the accumulator's `m_carry`/`m_data` on a capture strobe, then applies an arithmetic right shift and saturation to a narrower output word. Results are queued in a small FIFO and presented on a valid/ready stream to the next SPU op. The accumulator has no backpressure, so captures arriving while the queue is full are dropped and counted.

## Interface
- `M_DATA_BITS`, 32: accumulator data width (`s_data`).
- `O_DATA_BITS`, 16: output width (`m_data`); must be ≤ `M_DATA_BITS`.
- `SHIFT`, 0: arithmetic right shift applied before saturation; range 0..`M_DATA_BITS`-1.
- `SIGNED`, 1: 1 treats `s_data` as signed and ignores `s_carry`; 0 treats `{s_carry, s_data}` as unsigned.
- `FIFO_DEPTH`, 4: output queue entries; power of two, ≥ 2.
- `clk`, in, 1: clock.
- `reset`, in, 1: one clock; reset is asynchronous and active-low.
- `cke`, in, 1: clock enable for all state.
- `s_carry`, in, 1: accumulator carry.
- `s_data`, in, `M_DATA_BITS`: accumulator value.
- `s_last`, in, 1: capture strobe; only effective with `s_valid`.
- `s_valid`, in, 1: `s_data` is valid.
- `s_clear_status`, in, 1: clears `m_drop` and `m_drop_count`.
- `m_data`, out, `O_DATA_BITS`: shifted and saturated result.
- `m_ovf`, out, 1: the result was saturated.
- `m_valid`, out, 1: output valid.
- `m_ready`, in, 1: downstream accepts.
- `m_drop`, out, 1: sticky; at least one capture was lost.
- `m_drop_count`, out, 8: count of lost captures; saturates at 255.

## Operation
- A capture occurs when `cke & s_valid & s_last`.
- Stage 1 register:
  - Value v is `s_data` sign-extended (`SIGNED`=1) or `{s_carry, s_data}` zero-extended (`SIGNED`=0).
  - v is shifted right arithmetically by `SHIFT`.
  - The result is clamped to [-2^(O-1), 2^(O-1)-1] when signed, or [0, 2^O-1] when unsigned.
  - `m_ovf` = 1 if clamping changed the value.
- Stage 2 is a FIFO holding {data, ovf}.
  - A push occurs when stage 1 is valid and either the FIFO is not full or a pop occurs in the same cycle.
  - Otherwise the entry is dropped: `m_drop` is set and `m_drop_count` increments (saturating).
- A pop occurs when `cke & m_valid & m_ready`. `m_data`/`m_ovf` show the FIFO head.
- If push and pop happen in the same cycle when the FIFO is full, both are accepted and nothing is dropped.
- If push and pop happen in the same cycle when the FIFO is empty, the entry is not bypassed; it becomes the head the next cycle.
- `s_clear_status` takes priority over a drop in the same cycle: counters read 0 afterwards.
- With `cke`=0, all state holds; `m_valid` stays stable and no pop occurs.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_ovf`=0, `m_drop`=0, `m_drop_count`=0; FIFO empty; stage 1 invalid.
- Reset clears state asynchronously. Release is sampled synchronously on `clk`.
- Latency: a capture at edge N raises `m_valid` after edge N+2 when the FIFO was empty and `cke` was high throughout.
- Handshake: once `m_valid` is asserted, `m_valid`, `m_data` and `m_ovf` are held until the pop.
- Throughput: one capture per cycle is sustained while `m_ready`=1.
- Assertion of `reset` during any operation immediately clears `m_valid` and discards all queued entries.

## Configuration
- `ELIXIRCHIP_ES1_SPU_OP_ACC_DRAIN_ROUND_EN`
  - Defined: before shifting, add 2^(`SHIFT`-1) to v (round half up), using one extra guard bit so the addition cannot wrap. Has no effect when `SHIFT`=0.
  - Undefined: plain truncation toward -inf.

## Structure
- Package `elixirchip_es1_spu_pkg` holds:
  - `drain_entry_t` typedef (data + ovf), parameterised via a macro or localparam width.
  - Localparam `DROP_CNT_BITS` = 8.
- Sub-module `elixirchip_es1_spu_fifo_sync`:
  - Show-ahead synchronous FIFO with ptr/count.
  - Exposes `full`, `empty`, `s_valid`/`m_ready` style ports and the same `reset`/`clk`/`cke`.

## Test plan
All scenarios use `M_DATA_BITS`=16, `O_DATA_BITS`=8, `SHIFT`=4.
- Rounding: capture 0x0128, `m_ready`=1.
  - Without the macro: `m_data`=0x12, `m_ovf`=0, `m_valid` at N+2.
  - With the macro: `m_data`=0x13.
- Signed saturation: capture 0x7FFF → `m_data`=0x7F, `m_ovf`=1. Capture 0x8000 → `m_data`=0x80, `m_ovf`=1.
- Unsigned carry (`SIGNED`=0): `s_carry`=1, `s_data`=0x0000 → `m_data`=0xFF, `m_ovf`=1. `s_carry`=0, `s_data`=0x00A0 → `m_data`=0x0A, `m_ovf`=0.
- Overflow and drops: `m_ready`=0, 6 back-to-back captures 1..6 (values <<4), `FIFO_DEPTH`=4.
  - Expect `m_drop`=1 and `m_drop_count`=1; the stage-1 slot is counted by the push rule.
  - Raising `m_ready` drains 1,2,3,4.
  - `s_clear_status` then reads `m_drop_count`=0.
- Full with concurrent pop: FIFO full, `m_ready`=1, capture on every cycle for 10 cycles → no drops; output order is preserved.
- Reset mid-stream: assert `reset` low while 3 entries are queued → `m_valid`=0 within the same cycle. After release, no stale entries are output.
